// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU logic slices.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  // Result-mux select; each logic slice owns one entry.
  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } alu_op_e;

endpackage

// File: rtl/alu_flag_reg.sv
// Result/flag register shared by the ALU logic slices: captures on valid, holds otherwise.
module alu_flag_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_zero,
  input  logic             i_ones,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_ones,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_result_p1;
  logic             r_zero_p1;
  logic             r_ones_p1;
  logic             r_vld_p1;

  // Stage p1: zero flag resets high so it agrees with the cleared result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_p1 <= '0;
      r_zero_p1   <= 1'b1;
      r_ones_p1   <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= i_valid;
      if (i_valid) begin
        r_result_p1 <= i_result;
        r_zero_p1   <= i_zero;
        r_ones_p1   <= i_ones;
      end
    end
  end

  assign o_result = r_result_p1;
  assign o_zero   = r_zero_p1;
  assign o_ones   = r_ones_p1;
  assign o_valid  = r_vld_p1;

endmodule

// File: rtl/alu_nor_gate.sv
// Bitwise NOR slice: combinational result for the ALU mux plus a registered, flagged copy.
module alu_nor_gate
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             ones_q,
  output logic             out_valid
);

  function automatic logic f_all_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  logic [WIDTH-1:0] w_nor_p0;
  logic             w_zero_p0;
  logic             w_ones_p0;

  // Stage p0: combinational NOR and flags; all-ones output means both operands were zero.
  assign w_nor_p0  = ~(A | B);
  assign w_zero_p0 = f_all_zero(w_nor_p0);
  assign w_ones_p0 = f_all_zero(A | B);

  assign result = w_nor_p0;

  // Stage p1: registered result and flags.
  alu_flag_reg #(
    .WIDTH(WIDTH)
  ) u_flag_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (in_valid),
    .i_result (w_nor_p0),
    .i_zero   (w_zero_p0),
    .i_ones   (w_ones_p0),
    .o_result (result_q),
    .o_zero   (zero_q),
    .o_ones   (ones_q),
    .o_valid  (out_valid)
  );

endmodule

// File: tb/tb_alu_nor_gate.sv
// Self-checking bench for alu_nor_gate at WIDTH=4 and WIDTH=1 against an arithmetic reference model.
module tb_alu_nor_gate;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       in_valid;
  logic [3:0] result;
  logic [3:0] result_q;
  logic       zero_q;
  logic       ones_q;
  logic       out_valid;

  logic [0:0] A1;
  logic [0:0] B1;
  logic [0:0] result1;
  logic [0:0] result1_q;
  logic       zero1_q;
  logic       ones1_q;
  logic       out1_valid;

  int checks;
  int errors;

  // Reference-model state for the registered outputs.
  int   exp_rq;
  logic exp_zq;
  logic exp_oq;
  logic exp_vld;
  int   exp1_rq;
  logic exp1_zq;
  logic exp1_oq;

  alu_nor_gate #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
    .result(result), .result_q(result_q), .zero_q(zero_q),
    .ones_q(ones_q), .out_valid(out_valid)
  );

  alu_nor_gate #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(A1), .B(B1), .in_valid(in_valid),
    .result(result1), .result_q(result1_q), .zero_q(zero1_q),
    .ones_q(ones1_q), .out_valid(out1_valid)
  );

  assign A1 = A[0:0];
  assign B1 = B[0:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A result bit is set exactly when neither operand has that bit set.
  function automatic int ref_nor(input int a, input int b, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++)
      if (((a >> i) % 2 == 0) && ((b >> i) % 2 == 0)) r += (1 << i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_rq  = 0;  exp_zq  = 1'b1; exp_oq  = 1'b0; exp_vld = 1'b0;
    exp1_rq = 0;  exp1_zq = 1'b1; exp1_oq = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".result_q"},  {60'd0, result_q}, 64'(exp_rq));
    chk({tag, ".zero_q"},    {63'd0, zero_q},   {63'd0, exp_zq});
    chk({tag, ".ones_q"},    {63'd0, ones_q},   {63'd0, exp_oq});
    chk({tag, ".out_valid"}, {63'd0, out_valid},{63'd0, exp_vld});
    chk({tag, ".w1.result_q"}, {63'd0, result1_q}, 64'(exp1_rq));
    chk({tag, ".w1.zero_q"},   {63'd0, zero1_q},   {63'd0, exp1_zq});
    chk({tag, ".w1.ones_q"},   {63'd0, ones1_q},   {63'd0, exp1_oq});
    chk({tag, ".w1.out_valid"},{63'd0, out1_valid},{63'd0, exp_vld});
  endtask

  // Drive one operation shortly after an edge, check the combinational path, then the registered one.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b, input logic v);
    A = a; B = b; in_valid = v;
    #1;
    chk({tag, ".result"},    {60'd0, result},  64'(ref_nor(int'(a), int'(b), 4)));
    chk({tag, ".w1.result"}, {63'd0, result1}, 64'(ref_nor(int'(a), int'(b), 1)));
    @(posedge clk);
    if (rst_n) begin
      if (v) begin
        exp_rq  = ref_nor(int'(a), int'(b), 4);
        exp_zq  = (exp_rq == 0);
        exp_oq  = (int'(a) + int'(b) == 0);
        exp1_rq = ref_nor(int'(a), int'(b), 1);
        exp1_zq = (exp1_rq == 0);
        exp1_oq = ((int'(a) % 2) + (int'(b) % 2) == 0);
      end
      exp_vld = v;
    end else begin
      model_reset();
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    A = 4'b0000; B = 4'b0000; in_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset");
    rst_n = 1'b1;

    step("basic",  4'b1001, 4'b1010, 1'b1);
    step("compl",  4'b0000, 4'b1111, 1'b1);
    step("zeros",  4'b0000, 4'b0000, 1'b1);

    step("hold_ld", 4'b1001, 4'b1010, 1'b1);
    step("hold",    4'b0000, 4'b0000, 1'b0);
    step("hold2",   4'b0110, 4'b0001, 1'b0);

    // Asynchronous reset between edges, with a valid operation pending.
    step("pre_rst", 4'b0011, 4'b0100, 1'b1);
    A = 4'b1001; B = 4'b1010; in_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst");
    chk("async_rst.result", {60'd0, result}, 64'(ref_nor(9, 10, 4)));
    A = 4'b0000; B = 4'b0000;
    #1;
    chk("async_rst.track", {60'd0, result}, 64'(ref_nor(0, 0, 4)));
    @(posedge clk);
    #1;
    check_regs("rst_hold");
    rst_n = 1'b1;
    step("post_rst", 4'b0101, 4'b0000, 1'b1);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step("sweep", 4'(a), 4'(b), 1'b1);

    for (int n = 0; n < 200; n++)
      step("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
